// File: rtl/soc_system_pio_in_capture.sv
// Avalon-MM input PIO: synchronizes and debounces external pins, captures
// qualifying edges into a sticky W1C register and raises a masked level irq.
module soc_system_pio_in_capture #(
  parameter int WIDTH           = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int EDGE_TYPE       = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync1_q, sync2_q;
  logic [WIDTH-1:0] deb_q, deb_d;
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];
  logic [WIDTH-1:0] commit;
  logic [WIDTH-1:0] cap_set, cap_clr;
  logic [WIDTH-1:0] irqmask_q, irqmask_d;
  logic [WIDTH-1:0] edgecap_q, edgecap_d;
  logic             irq_q, irq_d;
  logic             wr_en;
  logic             unused_wd;

  // A commit always moves deb to the current sync2 level, so that level
  // tells the direction of the accepted edge.
  function automatic logic [WIDTH-1:0] edge_select(input logic [WIDTH-1:0] commit_v,
                                                   input logic [WIDTH-1:0] level);
    logic [WIDTH-1:0] rise, fall;
    rise = commit_v & level;
    fall = commit_v & ~level;
    if (EDGE_TYPE == 0)      edge_select = rise;
    else if (EDGE_TYPE == 1) edge_select = fall;
    else                     edge_select = rise | fall;
  endfunction

  function automatic logic [31:0] zext(input logic [WIDTH-1:0] v);
    zext = '0;
    zext[WIDTH-1:0] = v;
  endfunction

  assign wr_en     = chipselect & ~write_n;
  assign unused_wd = ^writedata;

  always_comb begin
    deb_d  = deb_q;
    cnt_d  = cnt_q;
    commit = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (sync2_q[i] == deb_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        deb_d[i]  = sync2_q[i];
        cnt_d[i]  = '0;
        commit[i] = 1'b1;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  assign cap_set = edge_select(commit, sync2_q);

  // Set wins over a same-cycle clear so a fresh edge is never lost.
  always_comb begin
    irqmask_d = irqmask_q;
    cap_clr   = '0;
    if (wr_en && address == 3'd2) irqmask_d = writedata[WIDTH-1:0];
    if (wr_en && address == 3'd3) cap_clr   = writedata[WIDTH-1:0];
    edgecap_d = (edgecap_q & ~cap_clr) | cap_set;
    irq_d     = |(edgecap_d & irqmask_d);
  end

  always_comb begin
    case (address)
      3'd0:    readdata = zext(deb_q);
      3'd1:    readdata = zext(sync2_q);
      3'd2:    readdata = zext(irqmask_q);
      3'd3:    readdata = zext(edgecap_q);
      default: readdata = '0;
    endcase
  end

  assign irq = irq_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      deb_q     <= '0;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
      irqmask_q <= '0;
      edgecap_q <= '0;
      irq_q     <= 1'b0;
    end else begin
      sync1_q   <= in_port;
      sync2_q   <= sync1_q;
      deb_q     <= deb_d;
      cnt_q     <= cnt_d;
      irqmask_q <= irqmask_d;
      edgecap_q <= edgecap_d;
      irq_q     <= irq_d;
    end
  end

endmodule

// File: tb/tb_soc_system_pio_in_capture.sv
// Bench for soc_system_pio_in_capture: rising, falling and any-edge instances
// share one bus and are checked every cycle against a history-window model.
module tb_soc_system_pio_in_capture;

  localparam int W = 2;
  localparam int D = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [2:0]    address = '0;
  logic          chipselect = 1'b0;
  logic          write_n = 1'b1;
  logic [31:0]   writedata = '0;
  logic [W-1:0]  in_port = '0;
  logic [31:0]   rd [3];
  logic          irq_w [3];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  soc_system_pio_in_capture #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .EDGE_TYPE(0)) u_rise (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd[0]), .irq(irq_w[0]));

  soc_system_pio_in_capture #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .EDGE_TYPE(1)) u_fall (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd[1]), .irq(irq_w[1]));

  soc_system_pio_in_capture #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .EDGE_TYPE(2)) u_any (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd[2]), .irq(irq_w[2]));

  // Model: a level is accepted once the last D synchronized samples all
  // disagree with the accepted level.
  typedef struct packed {
    logic [W-1:0]          s1;
    logic [W-1:0]          s2;
    logic [W-1:0]          deb;
    logic [W-1:0]          mask;
    logic [D-1:0][W-1:0]   hist;
    logic [2:0][W-1:0]     cap;
    logic [2:0]            irq;
  } model_t;

  model_t m;

  function automatic model_t model_next(input model_t cur, input logic wr,
                                        input logic [2:0] a, input logic [W-1:0] wd,
                                        input logic [W-1:0] pin);
    model_t n;
    logic [W-1:0] acc, rise, fall, clr;
    logic all_diff;
    n = cur;
    n.hist = {cur.hist[D-2:0], cur.s2};
    acc = '0;
    for (int i = 0; i < W; i++) begin
      all_diff = 1'b1;
      for (int j = 0; j < D; j++)
        if (n.hist[j][i] == cur.deb[i]) all_diff = 1'b0;
      acc[i] = all_diff;
    end
    rise  = acc & ~cur.deb;
    fall  = acc & cur.deb;
    n.deb = cur.deb ^ acc;
    n.s2  = cur.s1;
    n.s1  = pin;
    clr   = (wr && a == 3'd3) ? wd : '0;
    if (wr && a == 3'd2) n.mask = wd;
    n.cap[0] = (cur.cap[0] & ~clr) | rise;
    n.cap[1] = (cur.cap[1] & ~clr) | fall;
    n.cap[2] = (cur.cap[2] & ~clr) | rise | fall;
    for (int k = 0; k < 3; k++) n.irq[k] = |(n.cap[k] & n.mask);
    return n;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) m <= '0;
    else m <= model_next(m, chipselect && !write_n, address, writedata[W-1:0], in_port);
  end

  function automatic logic [31:0] exp_rd(input int k);
    logic [31:0] r;
    r = '0;
    case (address)
      3'd0: r[W-1:0] = m.deb;
      3'd1: r[W-1:0] = m.s2;
      3'd2: r[W-1:0] = m.mask;
      3'd3: r[W-1:0] = m.cap[k];
      default: r = '0;
    endcase
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("model_rd%0d_a%0d", k, address), rd[k], exp_rd(k));
      chk($sformatf("model_irq%0d", k), {31'b0, irq_w[k]}, {31'b0, m.irq[k]});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic bus_wr(input logic [2:0] a, input logic [31:0] d);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = a;
    writedata  = d;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rdchk3(input string name, input logic [2:0] a,
                        input logic [31:0] e0, input logic [31:0] e1, input logic [31:0] e2);
    address = a;
    #1;
    chk({name, "_rise"}, rd[0], e0);
    chk({name, "_fall"}, rd[1], e1);
    chk({name, "_any"},  rd[2], e2);
  endtask

  task automatic irqchk3(input string name, input logic e0, input logic e1, input logic e2);
    chk({name, "_rise"}, {31'b0, irq_w[0]}, {31'b0, e0});
    chk({name, "_fall"}, {31'b0, irq_w[1]}, {31'b0, e1});
    chk({name, "_any"},  {31'b0, irq_w[2]}, {31'b0, e2});
  endtask

  initial begin
    int r;
    int hold;
    ticks(3);

    // Reset release with both inputs already high
    in_port = 2'b11;
    reset_n = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (i <= 5) rdchk3("deb_hold", 3'd0, 0, 0, 0);
      else        rdchk3("deb_rise", 3'd0, 3, 3, 3);
    end
    rdchk3("cap_after_rel", 3'd3, 3, 0, 3);
    irqchk3("irq_masked", 0, 0, 0);

    // Short glitch never qualifies
    in_port = 2'b00;
    ticks(8);
    bus_wr(3'd3, 32'h3);
    rdchk3("cap_cleared", 3'd3, 0, 0, 0);
    in_port = 2'b01;
    ticks(2);
    rdchk3("sync_pulse", 3'd1, 1, 1, 1);
    tick();
    in_port = 2'b00;
    ticks(8);
    rdchk3("glitch_deb", 3'd0, 0, 0, 0);
    rdchk3("glitch_cap", 3'd3, 0, 0, 0);
    irqchk3("glitch_irq", 0, 0, 0);

    // Masked rise raises irq, W1C drops it
    bus_wr(3'd2, 32'h1);
    in_port = 2'b01;
    ticks(8);
    rdchk3("rise_cap", 3'd3, 1, 0, 1);
    irqchk3("rise_irq", 1, 0, 1);
    bus_wr(3'd3, 32'h1);
    rdchk3("w1c_cap", 3'd3, 0, 0, 0);
    irqchk3("w1c_irq", 0, 0, 0);

    // Clear landing on the commit edge loses to the set
    in_port = 2'b00;
    ticks(8);
    bus_wr(3'd3, 32'h3);
    in_port = 2'b01;
    ticks(5);
    bus_wr(3'd3, 32'h1);
    rdchk3("setwins_cap", 3'd3, 1, 0, 1);
    irqchk3("setwins_irq", 1, 0, 1);

    // Bit1 toggles with long holds: any-edge captures both directions
    bus_wr(3'd3, 32'h3);
    in_port = 2'b11;
    ticks(10);
    rdchk3("tog_up_cap", 3'd3, 2, 0, 2);
    bus_wr(3'd3, 32'h2);
    rdchk3("tog_clr_cap", 3'd3, 0, 0, 0);
    in_port = 2'b01;
    ticks(10);
    rdchk3("tog_dn_cap", 3'd3, 0, 2, 2);

    // Reset in the middle of a debounce run
    in_port = 2'b00;
    ticks(8);
    in_port = 2'b01;
    ticks(4);
    reset_n = 1'b0;
    ticks(2);
    rdchk3("rst_mask", 3'd2, 0, 0, 0);
    rdchk3("rst_cap", 3'd3, 0, 0, 0);
    reset_n = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (i <= 5) rdchk3("rst_requal_lo", 3'd0, 0, 0, 0);
      else        rdchk3("rst_requal_hi", 3'd0, 1, 1, 1);
    end

    // Randomized traffic checked by the per-cycle compare process
    hold = 0;
    for (int c = 0; c < 3000; c++) begin
      if (hold == 0) begin
        in_port = W'($urandom);
        hold = $urandom_range(1, 9);
      end
      hold--;
      r = $urandom_range(0, 199);
      if (r < 40) begin
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = (r < 25) ? (($urandom_range(0, 1) == 1) ? 3'd2 : 3'd3)
                              : 3'($urandom_range(0, 7));
        writedata  = $urandom;
      end else begin
        if ($urandom_range(0, 1) == 1) begin
          chipselect = 1'b1;
          write_n    = 1'b1;
        end else begin
          chipselect = 1'b0;
          write_n    = 1'($urandom_range(0, 1));
        end
        address   = 3'($urandom_range(0, 7));
        writedata = $urandom;
      end
      reset_n = (r != 199);
      tick();
    end
    chipselect = 1'b0;
    write_n    = 1'b1;
    reset_n    = 1'b1;
    ticks(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
